// File: rtl/membus_pkg.sv
// Shared definitions for the PDP-6 core-memory bus slave.
//   state_e   : sequencer states of the memory cycle
//   MB_W      : data word width (36)
//   MA_W      : bus address width, bits 21:35 (15)
//   SEL_W     : module-select width, bits 18:21 (4)
//   ARRAY_AW  : array address width, bits 22:35 (14)
//   CNT_W     : latency counter width (holds 1..15)
package membus_pkg;

  localparam int MB_W     = 36;
  localparam int MA_W     = 15;
  localparam int SEL_W    = 4;
  localparam int ARRAY_AW = 14;
  localparam int CNT_W    = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK   = 3'd1,
    RD    = 3'd2,
    RDRS  = 3'd3,
    WWAIT = 3'd4,
    WR    = 3'd5,
    DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/core_mem_array.sv
// 16384 x 36 single-port word store with registered read.
//   clk_i    : clock
//   we_i     : write wdata_i to addr_i at the clock edge
//   re_i     : load rdata_o from addr_i at the clock edge
//   addr_i   : word address
//   wdata_i  : write data
//   rdata_o  : registered read data (holds until the next read)
// Contents are deliberately not reset: core memory keeps its data.
module core_mem_array
  import membus_pkg::*;
(
  input  logic                clk_i,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [ARRAY_AW-1:0] addr_i,
  input  logic [MB_W-1:0]     wdata_i,
  output logic [MB_W-1:0]     rdata_o
);

  logic [MB_W-1:0] mem_q [0:(1<<ARRAY_AW)-1];
  logic [MB_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/membus_core_mem.sv
// Core-memory slave for one port of the PDP-6 memory bus.
// Accepts a selected request, acknowledges the address for one cycle, then
// runs a read / read-restore / read-modify-write / write cycle with fixed
// latencies against a 16K x 36 array.
//   clk, reset         : clock, synchronous active-high reset
//   membus_rq_cyc      : cycle request (must drop before the next acceptance)
//   membus_rd_rq/wr_rq : read / write requested
//   membus_ma          : address bits 21:35 (bit 21 ignored)
//   membus_sel         : module select bits 18:21
//   membus_fmc_select  : fast memory selected, never respond
//   membus_wr_rs       : processor write data valid on membus_mb_write
//   membus_mb_write    : wired-OR bus data
//   membus_addr_ack    : one-cycle address acknowledge
//   membus_rd_rs       : one-cycle read restart, data on membus_mb_read
//   membus_mb_read     : read data, zero whenever membus_rd_rs is low
//   dbg_state          : current sequencer state (membus_pkg::state_e)
//   status_timeout     : sticky write-wait timeout flag (MEMBUS_TIMEOUT_EN only)
// Build option MEMBUS_TIMEOUT_EN: bound the wait for membus_wr_rs to TIMEOUT
// cycles; on expiry the held data register is written back.
// Handshake: a request is taken only in IDLE when rq_cyc, select and a
// read/write request coincide; afterwards only wr_rs (in WWAIT) and rq_cyc
// (in DONE) are looked at, so each held request is served exactly once.
module membus_core_mem
  import membus_pkg::*;
#(
  parameter logic [SEL_W-1:0] SEL_MATCH = 4'h0,
  parameter int               RD_LAT    = 3,
  parameter int               WR_LAT    = 3,
  parameter int               TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             membus_wr_rs,
  input  logic             membus_rq_cyc,
  input  logic             membus_rd_rq,
  input  logic             membus_wr_rq,
  input  logic [MA_W-1:0]  membus_ma,
  input  logic [SEL_W-1:0] membus_sel,
  input  logic             membus_fmc_select,
  input  logic [MB_W-1:0]  membus_mb_write,
  output logic             membus_addr_ack,
  output logic             membus_rd_rs,
  output logic [MB_W-1:0]  membus_mb_read,
`ifdef MEMBUS_TIMEOUT_EN
  output logic             status_timeout,
`endif
  output logic [2:0]       dbg_state
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ARRAY_AW-1:0] addr_q, addr_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [MB_W-1:0]     data_q, data_d;

  logic                sel_hit;
  logic                rd_last, wr_last;
  logic                arr_we, arr_re;
  logic [MB_W-1:0]     arr_rdata;

`ifdef MEMBUS_TIMEOUT_EN
  localparam int TMO_W = 16;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             status_q, status_d;
  logic             unused_bits;
  assign unused_bits = membus_ma[MA_W-1];
`else
  logic unused_bits;
  assign unused_bits = membus_ma[MA_W-1] ^ (TIMEOUT == 0);
`endif

  assign sel_hit = membus_rq_cyc & ~membus_fmc_select &
                   (membus_sel == SEL_MATCH) & (membus_rd_rq | membus_wr_rq);
  assign rd_last = (cnt_q == CNT_W'(RD_LAT - 1));
  assign wr_last = (cnt_q == CNT_W'(WR_LAT - 1));

  core_mem_array u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (addr_q),
    .wdata_i (data_q),
    .rdata_o (arr_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
`ifdef MEMBUS_TIMEOUT_EN
      tmo_q    <= '0;
      status_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
`ifdef MEMBUS_TIMEOUT_EN
      tmo_q    <= tmo_d;
      status_q <= status_d;
`endif
    end
  end

  // Next-state logic. The latency counter restarts from zero whenever it is
  // not actively counting, so each RD/WR phase begins at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    data_d  = data_q;
`ifdef MEMBUS_TIMEOUT_EN
    tmo_d    = '0;
    status_d = status_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sel_hit) begin
          addr_d  = membus_ma[ARRAY_AW-1:0];
          rd_d    = membus_rd_rq;
          wr_d    = membus_wr_rq;
          state_d = ACK;
        end
      end
      ACK: begin
        if (rd_q) begin
          state_d = RD;
        end else begin
          data_d  = '0;
          state_d = WWAIT;
        end
      end
      RD: begin
        if (rd_last) state_d = RDRS;
        else         cnt_d   = cnt_q + 1'b1;
      end
      RDRS: begin
        // Keep the word just read: it is the restore value, or the fallback
        // for a read-modify-write whose write data never arrives.
        data_d  = arr_rdata;
        state_d = wr_q ? WWAIT : WR;
      end
      WWAIT: begin
        if (membus_wr_rs) begin
          data_d  = membus_mb_write;
          state_d = WR;
        end
`ifdef MEMBUS_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          status_d = 1'b1;
          state_d  = WR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      WR: begin
        if (wr_last) state_d = DONE;
        else         cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        if (!membus_rq_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Gating with reset makes an abort visible in the reset cycle
  // itself and suppresses the array write of an interrupted cycle.
  always_comb begin
    arr_re          = (state_q == RD) && rd_last;
    arr_we          = (state_q == WR) && wr_last && !reset;
    membus_addr_ack = (state_q == ACK) && !reset;
    membus_rd_rs    = (state_q == RDRS) && !reset;
    membus_mb_read  = membus_rd_rs ? arr_rdata : '0;
  end

  assign dbg_state = state_q;
`ifdef MEMBUS_TIMEOUT_EN
  assign status_timeout = status_q;
`endif

endmodule

// File: tb/tb_membus_core_mem.sv
module tb_membus_core_mem;

  localparam logic [3:0] SEL    = 4'h0;
  localparam int         RD_LAT = 3;
  localparam int         WR_LAT = 3;
  localparam int         TMO    = 40;

  logic        clk;
  logic        reset;
  logic        membus_wr_rs;
  logic        membus_rq_cyc;
  logic        membus_rd_rq;
  logic        membus_wr_rq;
  logic [14:0] membus_ma;
  logic [3:0]  membus_sel;
  logic        membus_fmc_select;
  logic [35:0] membus_mb_write;
  logic        membus_addr_ack;
  logic        membus_rd_rs;
  logic [35:0] membus_mb_read;
  logic [2:0]  dbg_state;
`ifdef MEMBUS_TIMEOUT_EN
  logic        status_timeout;
`endif

  membus_core_mem #(
    .SEL_MATCH (SEL),
    .RD_LAT    (RD_LAT),
    .WR_LAT    (WR_LAT),
    .TIMEOUT   (TMO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .membus_wr_rs      (membus_wr_rs),
    .membus_rq_cyc     (membus_rq_cyc),
    .membus_rd_rq      (membus_rd_rq),
    .membus_wr_rq      (membus_wr_rq),
    .membus_ma         (membus_ma),
    .membus_sel        (membus_sel),
    .membus_fmc_select (membus_fmc_select),
    .membus_mb_write   (membus_mb_write),
    .membus_addr_ack   (membus_addr_ack),
    .membus_rd_rs      (membus_rd_rs),
    .membus_mb_read    (membus_mb_read),
`ifdef MEMBUS_TIMEOUT_EN
    .status_timeout    (status_timeout),
`endif
    .dbg_state         (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];        // expected read data, in order
  int          exp_rs_cyc_q[$]; // expected cycle of each rd_rs
  int          exp_ack_q[$];    // expected cycle of each addr_ack
  logic [35:0] model [int];     // reference memory contents

  int          m_cyc;
  logic [35:0] m_dat;

  always @(negedge clk) begin
    checks++;
    if (!membus_rd_rs && membus_mb_read != 36'd0) begin
      errors++;
      $display("FAIL idle_bus_zero: mb_read=%o while rd_rs low, required 0", membus_mb_read);
    end
    if (membus_addr_ack) begin
      checks++;
      if (exp_ack_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: addr_ack=1 at cycle %0d, required 0", cyc);
      end else begin
        m_cyc = exp_ack_q.pop_front();
        if (m_cyc != cyc) begin
          errors++;
          $display("FAIL ack_cycle: got cycle %0d, required cycle %0d", cyc, m_cyc);
        end
      end
    end
    if (membus_rd_rs) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_rs: rd_rs=1 at cycle %0d data=%o, required no response", cyc, membus_mb_read);
      end else begin
        m_dat = exp_q.pop_front();
        m_cyc = exp_rs_cyc_q.pop_front();
        if (m_dat !== membus_mb_read || m_cyc != cyc) begin
          errors++;
          $display("FAIL read_data: got %o at cycle %0d, required %o at cycle %0d",
                   membus_mb_read, cyc, m_dat, m_cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    membus_rq_cyc     = 1'b0;
    membus_rd_rq      = 1'b0;
    membus_wr_rq      = 1'b0;
    membus_wr_rs      = 1'b0;
    membus_fmc_select = 1'b0;
    membus_sel        = SEL;
    membus_ma         = 15'd0;
    membus_mb_write   = 36'd0;
  endtask

  // One processor bus cycle. skip_wrrs leaves a write phase without wr_rs;
  // hold keeps rq_cyc asserted for that many cycles after the data phases.
  task automatic bus_cycle(input bit rd, input bit wr, input logic [13:0] addr,
                           input logic [35:0] wdata, input logic [3:0] sel,
                           input bit fmc, input bit skip_wrrs, input int hold);
    bit hit;
    bit seen;
    int n;
    logic top_bit;
    hit = (rd || wr) && !fmc && (sel == SEL);
    top_bit = 1'($urandom);
    @(posedge clk); #1;
    membus_rq_cyc     = 1'b1;
    membus_rd_rq      = rd;
    membus_wr_rq      = wr;
    membus_ma         = {top_bit, addr};
    membus_sel        = sel;
    membus_fmc_select = fmc;
    if (!hit) begin
      // Tempt the block with write data too; nothing may happen.
      membus_wr_rs    = 1'b1;
      membus_mb_write = {4'($urandom), $urandom};
      repeat (50) @(posedge clk);
      #1 idle_inputs();
      return;
    end
    exp_ack_q.push_back(cyc + 1);
    if (rd) begin
      exp_q.push_back(model[int'(addr)]);
      exp_rs_cyc_q.push_back(cyc + 2 + RD_LAT);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (membus_addr_ack) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ack_timeout: addr_ack=0 for 8 cycles, required 1");
    end
    // Address is ignored after acknowledge.
    @(posedge clk); #1;
    membus_ma = 15'($urandom);
    if (rd) begin
      seen = 1'b0;
      for (int i = 0; i < RD_LAT + 6; i++) begin
        @(negedge clk);
        if (membus_rd_rs) begin seen = 1'b1; break; end
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL rd_rs_timeout: rd_rs=0 for %0d cycles, required 1", RD_LAT + 6);
      end
    end
    if (wr && !skip_wrrs) begin
      n = $urandom_range(0, 3);
      repeat (n + 1) @(posedge clk);
      #1;
      membus_wr_rs    = 1'b1;
      membus_mb_write = wdata;
      @(posedge clk); #1;
      membus_wr_rs    = 1'b0;
      membus_mb_write = {4'($urandom), $urandom};
      model[int'(addr)] = wdata;
    end
    repeat (hold) @(posedge clk);
    #1 idle_inputs();
    repeat (WR_LAT + 4 + ((wr && skip_wrrs) ? TMO + 2 : 0)) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [13:0] pool [8];
  logic [35:0] wd;
  int          op;

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (membus_addr_ack !== 1'b0 || membus_rd_rs !== 1'b0 || membus_mb_read !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b rd_rs=%b data=%o, required 0 0 0",
               membus_addr_ack, membus_rd_rs, membus_mb_read);
    end
`ifdef MEMBUS_TIMEOUT_EN
    checks++;
    if (status_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: status_timeout=%b, required 0", status_timeout);
    end
`endif
    @(posedge clk); #1 reset = 1'b0;

    // Write-only, read back twice, read-modify-write, read back.
    bus_cycle(0, 1, 14'o01234, 36'o123456654321, SEL, 0, 0, 0);
    bus_cycle(1, 0, 14'o01234, 36'd0, SEL, 0, 0, 0);
    bus_cycle(1, 0, 14'o01234, 36'd0, SEL, 0, 0, 0);
    bus_cycle(1, 1, 14'o01234, 36'o777, SEL, 0, 0, 0);
    bus_cycle(1, 0, 14'o01234, 36'd0, SEL, 0, 0, 0);

    // Deselected writes must not respond nor touch the array.
    bus_cycle(0, 1, 14'o01234, 36'o111, 4'h1, 0, 0, 0);
    bus_cycle(0, 1, 14'o01234, 36'o222, SEL, 1, 0, 0);
    bus_cycle(1, 0, 14'o01234, 36'd0, SEL, 0, 0, 0);

    // Request held long after completion: exactly one acknowledge.
    bus_cycle(1, 0, 14'o01234, 36'd0, SEL, 0, 0, 12);
    bus_cycle(0, 1, 14'o01234, 36'o1, SEL, 0, 0, 15);

    // Reset in the first WR cycle of a write-only cycle: no array write.
    @(posedge clk); #1;
    membus_rq_cyc = 1'b1;
    membus_wr_rq  = 1'b1;
    membus_ma     = {1'b0, 14'o01234};
    exp_ack_q.push_back(cyc + 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    membus_wr_rs    = 1'b1;
    membus_mb_write = 36'o555555;
    @(posedge clk); #1;
    membus_wr_rs = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    checks++;
    if (membus_addr_ack !== 1'b0 || membus_rd_rs !== 1'b0 || membus_mb_read !== 36'd0) begin
      errors++;
      $display("FAIL reset_midcycle: ack=%b rd_rs=%b data=%o, required 0 0 0",
               membus_addr_ack, membus_rd_rs, membus_mb_read);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    repeat (WR_LAT + 3) @(posedge clk);
    bus_cycle(1, 0, 14'o01234, 36'd0, SEL, 0, 0, 0);

`ifdef MEMBUS_TIMEOUT_EN
    // Read-modify-write abandoned by the processor: old data restored.
    bus_cycle(1, 1, 14'o01234, 36'd0, SEL, 0, 1, 0);
    checks++;
    if (status_timeout !== 1'b1) begin
      errors++;
      $display("FAIL status_timeout: got %b, required 1", status_timeout);
    end
    bus_cycle(1, 0, 14'o01234, 36'd0, SEL, 0, 0, 0);
`endif

    // Randomised traffic over a small address pool.
    for (int i = 0; i < 8; i++) begin
      pool[i] = 14'($urandom_range(0, 16383));
      wd = {4'($urandom), $urandom};
      bus_cycle(0, 1, pool[i], wd, SEL, 0, 0, $urandom_range(0, 3));
    end
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 19);
      wd = {4'($urandom), $urandom};
      if (op == 0)
        bus_cycle(1, 1, pool[$urandom_range(0, 7)], wd, 4'($urandom_range(1, 15)), 0, 0, 0);
      else if (op < 7)
        bus_cycle(0, 1, pool[$urandom_range(0, 7)], wd, SEL, 0, 0, $urandom_range(0, 4));
      else if (op < 14)
        bus_cycle(1, 0, pool[$urandom_range(0, 7)], wd, SEL, 0, 0, $urandom_range(0, 4));
      else
        bus_cycle(1, 1, pool[$urandom_range(0, 7)], wd, SEL, 0, 0, $urandom_range(0, 4));
    end
    for (int i = 0; i < 8; i++)
      bus_cycle(1, 0, pool[i], 36'd0, SEL, 0, 0, 0);

    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || exp_ack_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads and %0d acks outstanding, required 0 and 0",
               exp_q.size(), exp_ack_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "time limit");
  end

endmodule
